// File: rtl/mem_swap_arb_if.sv
// Bus bundle between the two requesting masters, the arbiter and the swap memory's W0/R0 ports.
// Lane i of every packed array belongs to master i.
interface mem_swap_arb_if #(
  parameter int NUM_LANES  = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_LANES-1:0]                 req_valid;
  logic [NUM_LANES-1:0]                 req_ready;
  logic [NUM_LANES-1:0]                 req_write;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_LANES-1:0][MASK_WIDTH-1:0] req_mask;

  logic [NUM_LANES-1:0]                 resp_valid;
  logic [NUM_LANES-1:0]                 resp_ready;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] resp_data;
  logic [NUM_LANES-1:0]                 resp_write;

  logic                  mem_w_en;
  logic [ADDR_WIDTH-1:0] mem_w_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [MASK_WIDTH-1:0] mem_w_mask;
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_WIDTH-1:0] mem_r_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask, resp_ready, mem_r_data,
    output req_ready, resp_valid, resp_data, resp_write,
           mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_en, mem_r_addr
  );

  // Requester / memory-model side
  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask, resp_ready, mem_r_data,
    input  req_ready, resp_valid, resp_data, resp_write,
           mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_en, mem_r_addr
  );
endinterface

// File: rtl/mem_swap_arb.sv
// Two-master round-robin arbiter in front of the single-W/single-R swap memory, with a skid slot per master.
// Define MEM_SWAP_ARB_FIXED_PRIO_EN to make master 0 always preferred (prio register removed).

// Per-master response slot: tracks the in-flight op and parks its result while resp_ready is low.
module mem_swap_arb_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  grant,
  input  logic                  grant_write,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  resp_ready,
  output logic                  elig,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_write
);
  logic                  pending;
  logic                  kind;
  logic                  held;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] live;

  // mem_r_data is only meaningful in the first cycle after the read, hence the hold copy.
  assign live       = kind ? '0 : rd_data;
  assign resp_valid = pending;
  assign resp_write = pending & kind;
  assign resp_data  = !pending ? '0 : (held ? hold : live);
  assign elig       = !pending | resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      kind    <= 1'b0;
      held    <= 1'b0;
      hold    <= '0;
    end else if (grant) begin
      // grant implies eligible, so any previous response is being consumed now
      pending <= 1'b1;
      kind    <= grant_write;
      held    <= 1'b0;
    end else if (pending && resp_ready) begin
      pending <= 1'b0;
      held    <= 1'b0;
    end else if (pending && !held) begin
      held <= 1'b1;
      hold <= live;
    end
  end
endmodule

module mem_swap_arb #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input logic          clock,
  input logic          reset,
  mem_swap_arb_if.slave bus
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0] mask;
  } req_t;

  req_t [NUM_LANES-1:0]                 req;
  req_t                                 gnt_req;
  logic [NUM_LANES-1:0]                 elig;
  logic [NUM_LANES-1:0]                 cand;
  logic [NUM_LANES-1:0]                 gnt;
  logic [NUM_LANES-1:0]                 gnt_write;
  logic [NUM_LANES-1:0]                 resp_ready;
  logic [NUM_LANES-1:0]                 resp_valid;
  logic [NUM_LANES-1:0]                 resp_write;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] resp_data;
  logic [DATA_WIDTH-1:0]                rd_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_req
    assign req[i]       = {bus.req_write[i], bus.req_addr[i], bus.req_data[i], bus.req_mask[i]};
    assign cand[i]      = bus.req_valid[i] & elig[i];
    assign gnt_write[i] = req[i].write;
  end

`ifdef MEM_SWAP_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt    = '0;
    gnt[0] = cand[0];
    gnt[1] = cand[1] & ~cand[0];
  end
`else
  logic prio;

  always_comb begin
    gnt = '0;
    if (cand[prio])       gnt[prio]  = 1'b1;
    else if (cand[~prio]) gnt[~prio] = 1'b1;
  end

  // Winner drops to lowest priority; idle cycles keep the current order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      prio <= 1'b0;
    else if (|gnt)  prio <= gnt[0];
  end
`endif

  assign bus.req_ready = gnt;

  always_comb begin
    gnt_req        = gnt[1] ? req[1] : req[0];
    bus.mem_w_en   = 1'b0;
    bus.mem_w_addr = '0;
    bus.mem_w_data = '0;
    bus.mem_w_mask = '0;
    bus.mem_r_en   = 1'b0;
    bus.mem_r_addr = '0;
    if (|gnt) begin
      if (gnt_req.write) begin
        bus.mem_w_en   = 1'b1;
        bus.mem_w_addr = gnt_req.addr;
        bus.mem_w_data = gnt_req.data;
        bus.mem_w_mask = gnt_req.mask;
      end else begin
        bus.mem_r_en   = 1'b1;
        bus.mem_r_addr = gnt_req.addr;
      end
    end
  end

  assign rd_data    = bus.mem_r_data;
  assign resp_ready = bus.resp_ready;

  mem_swap_arb_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot [NUM_LANES-1:0] (
    .clock      (clock),
    .reset      (reset),
    .grant      (gnt),
    .grant_write(gnt_write),
    .rd_data    (rd_data),
    .resp_ready (resp_ready),
    .elig       (elig),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_write (resp_write)
  );

  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_write = resp_write;
endmodule

// File: tb/tb_mem_swap_arb.sv
// Directed bench for mem_swap_arb: sparse memory model with one-cycle read latency, hand-computed responses.
// Inputs change on the falling edge; everything is sampled 1ns later.
module tb_mem_swap_arb;
  logic clock = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  mem_swap_arb_if #(.NUM_LANES(2), .ADDR_WIDTH(20), .DATA_WIDTH(64), .MASK_WIDTH(8)) bus ();

  mem_swap_arb #(.ADDR_WIDTH(20), .DATA_WIDTH(64), .MASK_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  localparam logic [63:0] D10 = 64'h1122334455667788;
  localparam logic [63:0] D40 = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] D20 = 64'h00000000FFFFFFFF;
  localparam logic [63:0] D30 = 64'hDEADBEEFCAFEF00D;

  // Memory model: preload constants unless overwritten
  logic [63:0] mem [logic [19:0]];

  function automatic logic [63:0] rd(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      20'h10:  return D10;
      20'h40:  return D40;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    w = old;
    for (int b = 0; b < 8; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    return w;
  endfunction

  always @(posedge clock) begin
    if (bus.mem_w_en) mem[bus.mem_w_addr] = merge(rd(bus.mem_w_addr), bus.mem_w_data, bus.mem_w_mask);
    if (bus.mem_r_en) bus.mem_r_data <= rd(bus.mem_r_addr);
  end

  // Requests must hold steady while valid and not yet accepted
  logic [1:0]       pv = '0;
  logic [1:0]       pr = '0;
  logic [1:0][92:0] ps = '0;
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && pv[i] && !pr[i])
        assert (bus.req_valid[i] &&
                {bus.req_write[i], bus.req_addr[i], bus.req_data[i], bus.req_mask[i]} == ps[i])
          else $error("request %0d changed while stalled", i);
      ps[i] <= {bus.req_write[i], bus.req_addr[i], bus.req_data[i], bus.req_mask[i]};
    end
    pv <= bus.req_valid;
    pr <= bus.req_ready;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setreq(input int i, input logic wr, input logic [19:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    bus.req_valid[i] = 1'b1;
    bus.req_write[i] = wr;
    bus.req_addr[i]  = a;
    bus.req_data[i]  = d;
    bus.req_mask[i]  = m;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_mask   = '0;
    bus.resp_ready = 2'b11;

    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_vld",   bus.resp_valid, 2'b00);
    chk("rst_rdy",   bus.req_ready, 2'b00);
    chk("rst_en",    {bus.mem_w_en, bus.mem_r_en}, 2'b00);
    chk("rst_data",  bus.resp_data[0] | bus.resp_data[1], 64'h0);
    chk("rst_kind",  bus.resp_write, 2'b00);
    @(negedge clock); reset = 1'b0;

    // single read by master 0
    @(negedge clock); setreq(0, 1'b0, 20'h10, 64'h0, 8'h0); #1;
    chk("rd_gnt",  bus.req_ready, 2'b01);
    chk("rd_ren",  bus.mem_r_en, 1'b1);
    chk("rd_addr", bus.mem_r_addr, 20'h10);
    chk("rd_wen",  bus.mem_w_en, 1'b0);
    @(negedge clock); bus.req_valid = '0; #1;
    chk("rd_vld",  bus.resp_valid, 2'b01);
    chk("rd_data", bus.resp_data[0], D10);
    chk("rd_kind", bus.resp_write[0], 1'b0);

    // masked write then read by master 1
    @(negedge clock); setreq(1, 1'b1, 20'h20, {64{1'b1}}, 8'h0F); #1;
    chk("wr_gnt",  bus.req_ready, 2'b10);
    chk("wr_wen",  bus.mem_w_en, 1'b1);
    chk("wr_mask", bus.mem_w_mask, 8'h0F);
    chk("wr_ren",  bus.mem_r_en, 1'b0);
    @(negedge clock); setreq(1, 1'b0, 20'h20, 64'h0, 8'h0); #1;
    chk("wr_ack",     {bus.resp_valid[1], bus.resp_write[1]}, 2'b11);
    chk("wr_ackdata", bus.resp_data[1], 64'h0);
    chk("wr_rd_gnt",  bus.req_ready, 2'b10);
    @(negedge clock); bus.req_valid = '0; #1;
    chk("wr_rd_data", bus.resp_data[1], D20);
    chk("wr_rd_kind", bus.resp_write[1], 1'b0);

    // contention: alternate grants starting with master 0
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) begin
        setreq(0, 1'b0, 20'h10, 64'h0, 8'h0);
        setreq(1, 1'b0, 20'h20, 64'h0, 8'h0);
      end
      #1;
      chk("rr_gnt", bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
      chk("rr_vld", bus.resp_valid, (k == 0) ? 2'b00 : ((k % 2) ? 2'b01 : 2'b10));
    end
    @(negedge clock); bus.req_valid[1] = 1'b0; #1;
    chk("rr_gnt_end", bus.req_ready, 2'b01);
    chk("rr_data1",   bus.resp_data[1], D20);
    @(negedge clock); bus.req_valid[0] = 1'b0; #1;
    chk("rr_data0",   bus.resp_data[0], D10);

    // backpressure on master 0 while master 1 keeps going
    @(negedge clock); setreq(0, 1'b0, 20'h40, 64'h0, 8'h0); #1;
    chk("bp_gnt_a", bus.req_ready, 2'b01);
    @(negedge clock);
    bus.resp_ready[0] = 1'b0;
    setreq(0, 1'b0, 20'h10, 64'h0, 8'h0);
    setreq(1, 1'b0, 20'h20, 64'h0, 8'h0);
    #1;
    chk("bp_first", bus.resp_data[0], D40);
    chk("bp_gnt_b", bus.req_ready, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      chk("bp_hold", bus.resp_data[0], D40);
      chk("bp_vld",  bus.resp_valid[0], 1'b1);
      chk("bp_gnt",  bus.req_ready, 2'b10);
    end
    @(negedge clock); bus.resp_ready[0] = 1'b1; #1;
    chk("bp_rel_gnt",  bus.req_ready, 2'b01);
    chk("bp_rel_data", bus.resp_data[0], D40);
    @(negedge clock); bus.req_valid[0] = 1'b0; #1;
    chk("bp_second", bus.resp_data[0], D10);
    chk("bp_gnt_m1", bus.req_ready, 2'b10);
    @(negedge clock); bus.req_valid[1] = 1'b0; #1;
    chk("bp_m1_data", bus.resp_data[1], D20);

    // reset in the response cycle of a read; earlier write must survive
    @(negedge clock); setreq(0, 1'b1, 20'h30, D30, 8'hFF); #1;
    chk("mr_wgnt",  bus.req_ready, 2'b01);
    chk("mr_waddr", bus.mem_w_addr, 20'h30);
    @(negedge clock); setreq(0, 1'b0, 20'h10, 64'h0, 8'h0); #1;
    chk("mr_ack",   bus.resp_write[0], 1'b1);
    chk("mr_rgnt",  bus.req_ready, 2'b01);
    @(negedge clock); bus.req_valid = '0; #1;
    chk("mr_pre",   bus.resp_valid, 2'b01);
    reset = 1'b1; #1;
    chk("mr_vld",   bus.resp_valid, 2'b00);
    chk("mr_data",  bus.resp_data[0], 64'h0);
    @(negedge clock);
    reset = 1'b0;
    setreq(0, 1'b0, 20'h30, 64'h0, 8'h0);
    setreq(1, 1'b0, 20'h10, 64'h0, 8'h0);
    #1;
    chk("mr_prio",  bus.req_ready, 2'b01);
    @(negedge clock); bus.req_valid[0] = 1'b0; #1;
    chk("mr_keep",  bus.resp_data[0], D30);
    chk("mr_gnt1",  bus.req_ready, 2'b10);
    @(negedge clock); bus.req_valid = '0; #1;
    chk("mr_data1", bus.resp_data[1], D10);

    // idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clock); #1;
      chk("idle", {bus.mem_w_en, bus.mem_r_en, bus.resp_valid}, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_swap_arb.md
# mem_swap_arb

Two-requester arbiter in front of the single-write-port/single-read-port swap memory model (`mem_ext`). Accepts read/write requests from two masters over valid/ready handshakes, grants one per cycle in round-robin order, and drives the memory's W0/R0 ports. Routes each one-cycle-latency read result, or a write acknowledge, back to the issuing master through a one-deep skid slot per master. Sits between the simulation bus adapters and `mem_ext`; all ports share one clock.

## Interface
- `ADDR_WIDTH`, 20, word address width; matches `mem_ext` W0/R0 address
- `DATA_WIDTH`, 64, data width; matches `mem_ext`
- `MASK_WIDTH`, 8, byte-mask width, DATA_WIDTH/8
- `clock`  in  1  sole clock; also drives memory W0_clk/R0_clk externally
- `reset`  in  1  asynchronous, active-high
- `req_valid[i]`, i=0..1  in  1  request valid
- `req_ready[i]`  out  1  request accepted this cycle when both valid and ready are high
- `req_write[i]`  in  1  1=write, 0=read
- `req_addr[i]`  in  ADDR_WIDTH  word address
- `req_data[i]`  in  DATA_WIDTH  write data
- `req_mask[i]`  in  MASK_WIDTH  write byte enables
- `resp_valid[i]`  out  1  response available
- `resp_ready[i]`  in  1  response consumed when both valid and ready are high
- `resp_data[i]`  out  DATA_WIDTH  read data; 0 for write acks
- `resp_write[i]`  out  1  response is a write ack
- `mem_w_en`, `mem_w_addr`, `mem_w_data`, `mem_w_mask`  out  1/ADDR/DATA/MASK  to `mem_ext` W0
- `mem_r_en`, `mem_r_addr`  out  1/ADDR  to `mem_ext` R0
- `mem_r_data`  in  DATA_WIDTH  from `mem_ext` R0; valid the cycle after `mem_r_en`

## Operation
- Per-master state: `pending_i` (transaction in flight or held), `kind_i` (read/write), hold register `hold_i`, `held_i` flag.
- Eligibility: `elig_i = !pending_i || (resp_valid_i && resp_ready_i)`.
- Arbitration: `prio` register selects the preferred master. Grant goes to `prio` if it is eligible and valid, else to the other master if it is eligible and valid. At most one grant per cycle. `req_ready_i` = granted_i, combinational.
- After any grant to master g: `prio <= 1-g`. No grant leaves `prio` unchanged.
- Granted write: `mem_w_en=1`, with addr/data/mask passed through the same cycle and `mem_r_en=0`. Granted read: `mem_r_en=1` with addr, `mem_w_en=0`. No grant drives both enables 0 and the addr/data buses 0.
- Cycle after grant (in-flight): `resp_valid_i=1`. `resp_data_i` = `mem_r_data` for a read, 0 for a write.
- If `resp_ready_i` is low, load `hold_i` with the response data and set `held_i`. `resp_valid_i` stays high with `hold_i` until consumed. Read data must not be re-sampled from `mem_r_data` after the first response cycle.
- A response handshake clears `pending_i` unless the same cycle grants master i again.
- Memory ordering: one operation per cycle, so a write granted in T is visible to a read granted in T+1 or later.

## Timing
- Reset values: `prio=0`, all `pending`/`held` 0, `resp_valid=0`, `resp_data=0`, `resp_write=0`, `req_ready=0`, mem enables 0.
- Grant-to-response latency: 1 cycle. Back-to-back grants to one master are possible when its response is consumed in the same cycle.
- Both masters requesting continuously with `resp_ready=1`: grants alternate 0,1,0,1, and each master sees one response every 2 cycles.
- A stalled `resp_ready_i` blocks only master i; the other master may take every cycle.
- Reset mid-operation: in-flight and held responses are dropped. A write already issued at a clock edge stays committed in memory.
- `req_*` must be stable while valid and not ready; the bench asserts this.

## Configuration
- `MEM_SWAP_ARB_FIXED_PRIO_EN` defined: master 0 always has priority, the `prio` register is removed, and master 1 is granted only when master 0 is not valid or not eligible.
- Undefined (default): round-robin as above.

## Test plan
- Single read: master 0 reads addr 0x10 preloaded with 0x1122334455667788. Expect `mem_r_en` high in cycle T, then `resp_valid[0]` in T+1 with that data.
- Masked write then read: master 1 writes 0xFFFF...FF with mask 0x0F to addr 0x20 (previously 0) in T, then reads it in T+1. Expect `resp_write[1]` ack, then read data 0x00000000FFFFFFFF.
- Contention: both masters issue continuous reads from reset. Expect grants in order 0,1,0,1 over 8 cycles. With `MEM_SWAP_ARB_FIXED_PRIO_EN`, expect 0 to be granted every cycle it is eligible.
- Backpressure: `resp_ready[0]=0` for 5 cycles after a read of 0xA5A5... while master 0 issues a second read to a different address. Expect `resp_data[0]` held at 0xA5A5..., master 0 not granted, and master 1 still granted.
- Reset mid-flight: assert `reset` in the response cycle of a pending read. Expect all `resp_valid` 0 immediately and `prio=0`. An earlier write is still readable after reset.
- Idle: no requests for 10 cycles. Expect mem enables 0 and no `resp_valid`.
